riscv_base_div_issue: RTL

Issue and writeback sequencer for the multi-cycle `riscv_base_divider`. It sits between decode and the divider. It accepts DIV/DIVU/REM/REMU from decode and presents them to the divider for exactly one cycle. It stalls the pipeline and flags RAW hazards against the pending rd, then writes the divider result into the register file.

---
 rtl/riscv_base_div_issue.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_base_div_issue.sv
// Issue/writeback sequencer between decode and riscv_base_divider.
// Optional WAIT/DRAIN watchdog is compiled in with `define RISCV_BASE_DIV_WATCHDOG_EN.

module riscv_base_div_issue #(
   parameter int WATCHDOG_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        dec_valid_i,
   input  logic [31:0] dec_opcode_i,
   input  logic [31:0] dec_pc_i,
   input  logic        dec_invalid_i,
   input  logic [4:0]  dec_rd_idx_i,
   input  logic [4:0]  dec_ra_idx_i,
   input  logic [4:0]  dec_rb_idx_i,
   input  logic [31:0] dec_ra_operand_i,
   input  logic [31:0] dec_rb_operand_i,
   output logic        dec_accept_o,
   output logic        stall_o,

   input  logic        flush_i,

   input  logic [4:0]  hazard_ra_idx_i,
   input  logic [4:0]  hazard_rb_idx_i,
   output logic        hazard_o,

   output logic        div_valid_o,
   output logic [31:0] div_opcode_o,
   output logic [31:0] div_pc_o,
   output logic        div_invalid_o,
   output logic [4:0]  div_rd_idx_o,
   output logic [4:0]  div_ra_idx_o,
   output logic [4:0]  div_rb_idx_o,
   output logic [31:0] div_ra_operand_o,
   output logic [31:0] div_rb_operand_o,

   input  logic        div_wb_valid_i,
   input  logic [31:0] div_wb_value_i,

   output logic        rf_wr_en_o,
   output logic [4:0]  rf_wr_idx_o,
   output logic [31:0] rf_wr_data_o,

   output logic        err_timeout_o
);

   // Encodings mirror INST_* / INST_*_MASK from riscv_base_defines.v so the block builds standalone.
   localparam logic [31:0] INST_DIV       = 32'h02004033;
   localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
   localparam logic [31:0] INST_DIVU      = 32'h02005033;
   localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
   localparam logic [31:0] INST_REM       = 32'h02006033;
   localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
   localparam logic [31:0] INST_REMU      = 32'h02007033;
   localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

   localparam logic [31:0] IDLE_RB_OPERAND = 32'h0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   state_t      state_q;
   logic [4:0]  rdIdx_q;

   logic        divValid_q;
   logic [31:0] divOpcode_q;
   logic [31:0] divPc_q;
   logic [4:0]  divRdIdx_q;
   logic [4:0]  divRaIdx_q;
   logic [4:0]  divRbIdx_q;
   logic [31:0] divRaOperand_q;
   logic [31:0] divRbOperand_q;

   logic        rfWrEn_q;
   logic [4:0]  rfWrIdx_q;
   logic [31:0] rfWrData_q;
   logic        errTimeout_q;

   logic        isDivRem;
   logic        acceptNow;
   logic        pendingRead;
   logic        wdExpired;

   assign isDivRem = ((dec_opcode_i & INST_DIV_MASK)  == INST_DIV)  |
                     ((dec_opcode_i & INST_DIVU_MASK) == INST_DIVU) |
                     ((dec_opcode_i & INST_REM_MASK)  == INST_REM)  |
                     ((dec_opcode_i & INST_REMU_MASK) == INST_REMU);

   assign acceptNow = (state_q == ST_IDLE) & dec_valid_i & isDivRem & ~dec_invalid_i;

   assign pendingRead = (hazard_ra_idx_i == rdIdx_q) | (hazard_rb_idx_i == rdIdx_q);

   assign dec_accept_o = acceptNow;
   assign stall_o      = (state_q != ST_IDLE) | acceptNow;
   // A flushed result is never written, so DRAIN does not raise a hazard.
   assign hazard_o     = ((state_q == ST_ISSUE) | (state_q == ST_WAIT)) &
                         (rdIdx_q != 5'd0) & pendingRead;

`ifdef RISCV_BASE_DIV_WATCHDOG_EN
   localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);

   logic [CNT_W-1:0] wdCnt_q;
   logic             wdCount;

   // Restart on every entry into WAIT or DRAIN, including the WAIT->DRAIN move on flush.
   assign wdCount = (state_q == ST_DRAIN) | ((state_q == ST_WAIT) & ~flush_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdCnt_q <= '0;
      end else if (wdCount) begin
         wdCnt_q <= wdCnt_q + 1'b1;
      end else begin
         wdCnt_q <= '0;
      end
   end

   assign wdExpired = (wdCnt_q == CNT_W'(WATCHDOG_CYCLES - 1));
`else
   logic unusedWatchdogCfg;

   assign wdExpired         = 1'b0;
   assign unusedWatchdogCfg = (WATCHDOG_CYCLES != 0);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         rdIdx_q        <= 5'd0;
         divValid_q     <= 1'b0;
         divOpcode_q    <= 32'd0;
         divPc_q        <= 32'd0;
         divRdIdx_q     <= 5'd0;
         divRaIdx_q     <= 5'd0;
         divRbIdx_q     <= 5'd0;
         divRaOperand_q <= 32'd0;
         divRbOperand_q <= IDLE_RB_OPERAND;
         rfWrEn_q       <= 1'b0;
         rfWrIdx_q      <= 5'd0;
         rfWrData_q     <= 32'd0;
         errTimeout_q   <= 1'b0;
      end else begin
         rfWrEn_q     <= 1'b0;
         errTimeout_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (acceptNow) begin
                  state_q        <= ST_ISSUE;
                  rdIdx_q        <= dec_rd_idx_i;
                  divValid_q     <= 1'b1;
                  divOpcode_q    <= dec_opcode_i;
                  divPc_q        <= dec_pc_i;
                  divRdIdx_q     <= dec_rd_idx_i;
                  divRaIdx_q     <= dec_ra_idx_i;
                  divRbIdx_q     <= dec_rb_idx_i;
                  divRaOperand_q <= dec_ra_operand_i;
                  divRbOperand_q <= dec_rb_operand_i;
               end
            end

            // The divider has sampled the request; drop back to safe idle values
            // so it never sees a zero divisor on its live inputs.
            ST_ISSUE: begin
               divValid_q     <= 1'b0;
               divOpcode_q    <= 32'd0;
               divPc_q        <= 32'd0;
               divRdIdx_q     <= 5'd0;
               divRaIdx_q     <= 5'd0;
               divRbIdx_q     <= 5'd0;
               divRaOperand_q <= 32'd0;
               divRbOperand_q <= IDLE_RB_OPERAND;
               state_q        <= flush_i ? ST_DRAIN : ST_WAIT;
            end

            ST_WAIT: begin
               if (div_wb_valid_i) begin
                  rfWrEn_q   <= (rdIdx_q != 5'd0) & ~flush_i;
                  rfWrIdx_q  <= rdIdx_q;
                  rfWrData_q <= div_wb_value_i;
                  state_q    <= ST_IDLE;
               end else if (flush_i) begin
                  state_q <= ST_DRAIN;
               end else if (wdExpired) begin
                  errTimeout_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end

            ST_DRAIN: begin
               if (div_wb_valid_i) begin
                  state_q <= ST_IDLE;
               end else if (wdExpired) begin
                  errTimeout_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign div_valid_o      = divValid_q;
   assign div_opcode_o     = divOpcode_q;
   assign div_pc_o         = divPc_q;
   assign div_invalid_o    = 1'b0;
   assign div_rd_idx_o     = divRdIdx_q;
   assign div_ra_idx_o     = divRaIdx_q;
   assign div_rb_idx_o     = divRbIdx_q;
   assign div_ra_operand_o = divRaOperand_q;
   assign div_rb_operand_o = divRbOperand_q;

   assign rf_wr_en_o    = rfWrEn_q;
   assign rf_wr_idx_o   = rfWrIdx_q;
   assign rf_wr_data_o  = rfWrData_q;
   assign err_timeout_o = errTimeout_q;

endmodule
